sar_adc_ctrl: RTL and testbench
===============================

Name: sar_adc_ctrl

Overview:
- Successive-approximation ADC controller: the receive-side counterpart of the sine generator's R2R DAC output path.
- Drives a 10-bit R2R DAC with trial codes and reads one external analog comparator pin (Vin vs Vdac).
- Resolves one bit per step, MSB first, and presents the converted sample with a one-cycle valid strobe.
- Sits in `top` next to the DAC pin mapping; `dac_code` bits are routed to the same board DAC pins.

Parameters:
- WIDTH, 10, DAC/sample resolution in bits.
- SETTLE_CYCLES, 4, cycles allowed for DAC and comparator analog settling after each DAC code change.
- SYNC_STAGES, 2, flip-flop stages synchronizing `cmp_in`; minimum 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  conversion request, level-sampled in IDLE.
- cmp_in  input  1  asynchronous comparator output; 1 = Vin >= Vdac.
- dac_code  output  WIDTH  trial code driven to R2R DAC.
- busy  output  1  high while a conversion is in progress.
- sample  output  WIDTH  last completed conversion result.
- sample_valid  output  1  one-cycle pulse when `sample` updates.

Behaviour:
- Reset values: `dac_code`=0, `busy`=0, `sample`=0, `sample_valid`=0, state=IDLE, synchronizer flops=0, settle counter=0.
- States: IDLE, SETTLE, DECIDE. Define T = SETTLE_CYCLES + SYNC_STAGES.
- IDLE:
  - If `start`=1 at edge k: `dac_code` <= 1<<(WIDTH-1), bit index <= WIDTH-1, counter <= 0, `busy` <= 1, go to SETTLE.
  - Otherwise hold `dac_code` at its previous value.
- SETTLE: counter increments each cycle; after exactly T cycles in SETTLE, go to DECIDE.
- DECIDE (one cycle) uses synchronized comparator c:
  - c=0: clear the current trial bit.
  - If index>0: also set the next lower bit, decrement index, counter <= 0, return to SETTLE.
  - If index==0: `sample` <= final code, `sample_valid` <= 1 for one cycle, `busy` <= 0, go to IDLE. `dac_code` holds the final code.
- Timing:
  - Each bit takes T+1 cycles.
  - `sample_valid` and `busy`=0 are first visible after edge k + WIDTH*(T+1); with defaults this is edge k+70.
- `start` while busy is ignored (no queuing).
- If `start` is still high in the IDLE cycle after completion, a new conversion starts at that edge: one idle cycle between conversions.
- Arithmetic: `dac_code` is built only by setting or clearing single bits, so it never wraps.
- Comparator boundaries:
  - Vin at full scale (c always 1) gives all ones.
  - Vin at or below 0 (c always 0) gives 0.
- Reset mid-conversion: next cycle is IDLE, `dac_code`=0, `busy`=0, no `sample_valid` pulse, `sample` cleared to 0.
- `cmp_in` is never used unsynchronized.

Optional Feature:
- Macro: SAR_CONTINUOUS_EN.
- Defined: in the final DECIDE with `start`=1, the block loads `sample` and pulses `sample_valid`, and on the same edge loads `dac_code` <= MSB trial and enters SETTLE. `busy` stays 1.
  - Back-to-back period is exactly WIDTH*(T+1) cycles (70 with defaults).
  - With `start`=0 it ends in IDLE as normal.
- Undefined: always returns to IDLE between conversions, giving a period of WIDTH*(T+1)+1.

Decomposition:
- Package `sar_pkg`:
  - state enum typedef (IDLE, SETTLE, DECIDE);
  - default constants ADC_WIDTH=10, ADC_SETTLE=4, ADC_SYNC=2;
  - shared with the DAC generator and the bench.
- One sub-module `cmp_sync`: parameterized SYNC_STAGES flop chain with synchronous active-low reset. The controller contains the FSM and counters only.

Test Plan:
- Bench comparator model: `cmp_in` = (dac_code <= VIN), delayed 3 cycles.
- Single conversion: reset, then `start` pulse at edge 0 with VIN=0x2A5 -> `busy` high edges 1-69, `sample`=0x2A5 with `sample_valid` high one cycle after edge 70, `dac_code`=0x2A5.
- Boundaries: VIN=0x3FF -> `sample`=0x3FF; VIN=0x000 -> `sample`=0x000; VIN=0x200 -> `sample`=0x200.
- `start` toggled every cycle during a conversion with VIN=0x155 -> exactly one `sample_valid`, `sample`=0x155, completion still at edge 70.
- `rst_n`=0 at edge 30 during a conversion with VIN=0x1FF -> next cycle `dac_code`=0, `busy`=0, `sample`=0, no valid pulse. Restart yields 0x1FF.
- `start` held high for 3 conversions with VIN=0x0F0 -> valid pulses spaced 71 cycles (SAR_CONTINUOUS_EN undefined) or 70 cycles (defined), each `sample`=0x0F0.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared SAR ADC definitions: controller state encoding and default sizing.
// Used by the controller, its synchronizer, the DAC generator side and the bench.
package sar_pkg;

   localparam int ADC_WIDTH  = 10;
   localparam int ADC_SETTLE = 4;
   localparam int ADC_SYNC   = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DECIDE = 2'd2
   } sar_state_e;

endpackage

// File: rtl/sar_adc_ctrl_cmp_sync.sv
// cmp_sync: flop chain bringing the asynchronous comparator pin into clk.
// SYNC_STAGES must be at least 2. The chain clears on synchronous active-low reset.
module cmp_sync
   import sar_pkg::*;
#(
   parameter int SYNC_STAGES = ADC_SYNC
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic sync_o
);

   logic [SYNC_STAGES-1:0] chain_q;

   // Shift the raw comparator level through the synchronizer chain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
      end
   end

   assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation ADC controller driving an R2R DAC
// and reading one external comparator (1 = Vin >= Vdac), MSB first.
// Optional feature macro: SAR_CONTINUOUS_EN -- when defined, a conversion that
// finishes with start high immediately launches the next one (no idle cycle).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; dac_code holds the last final code
// SETTLE | trial code applied; wait T = SETTLE_CYCLES + SYNC_STAGES cycles
// DECIDE | keep or clear the trial bit from the synchronized comparator
module sar_adc_ctrl
   import sar_pkg::*;
#(
   parameter int WIDTH         = ADC_WIDTH,
   parameter int SETTLE_CYCLES = ADC_SETTLE,
   parameter int SYNC_STAGES   = ADC_SYNC
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cmp_in,
   output logic [WIDTH-1:0] dac_code,
   output logic             busy,
   output logic [WIDTH-1:0] sample,
   output logic             sample_valid
);

   // Settle time covers both analog settling and the synchronizer latency,
   // so the comparator bit seen in DECIDE reflects the current trial code.
   localparam int T     = SETTLE_CYCLES + SYNC_STAGES;
   localparam int CNT_W = $clog2(T + 1);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T - 1);
   localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};

   sar_state_e       state_q, state_d;
   logic [WIDTH-1:0] dac_q, dac_d;
   logic [WIDTH-1:0] sample_q, sample_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;

   logic             cmp_s;
   logic [WIDTH-1:0] bit_mask;
   logic [WIDTH-1:0] kept_code;

   cmp_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_cmp_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (cmp_in),
      .sync_o  (cmp_s)
   );

   // Current trial bit, and the code after resolving it against the comparator.
   assign bit_mask  = WIDTH'(1) << idx_q;
   assign kept_code = cmp_s ? dac_q : (dac_q & ~bit_mask);

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         dac_q    <= '0;
         sample_q <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         dac_q    <= dac_d;
         sample_q <= sample_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
      end
   end

   // Next-state and output logic for the bit-serial approximation sequence.
   always_comb begin
      state_d  = state_q;
      dac_d    = dac_q;
      sample_d = sample_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      valid_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               dac_d   = MSB_CODE;
               idx_d   = IDX_MSB;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SETTLE;
            end
         end

         SETTLE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = DECIDE;
            end
         end

         DECIDE: begin
            if (idx_q != '0) begin
               dac_d   = kept_code | (bit_mask >> 1);
               idx_d   = idx_q - IDX_W'(1);
               cnt_d   = '0;
               state_d = SETTLE;
            end else begin
               sample_d = kept_code;
               valid_d  = 1'b1;
               dac_d    = kept_code;
`ifdef SAR_CONTINUOUS_EN
               if (start) begin
                  dac_d   = MSB_CODE;
                  idx_d   = IDX_MSB;
                  cnt_d   = '0;
                  state_d = SETTLE;
               end else begin
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end
`else
               busy_d  = 1'b0;
               state_d = IDLE;
`endif
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign dac_code     = dac_q;
   assign busy         = busy_q;
   assign sample       = sample_q;
   assign sample_valid = valid_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl with a delayed ideal comparator model.
module tb_sar_adc_ctrl;
   import sar_pkg::*;

   localparam int W   = ADC_WIDTH;
   localparam int LAT = ADC_WIDTH * (ADC_SETTLE + ADC_SYNC + 1);
`ifdef SAR_CONTINUOUS_EN
   localparam int PERIOD = LAT;
`else
   localparam int PERIOD = LAT + 1;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         cmp_in;
   logic [W-1:0] dac_code;
   logic         busy;
   logic [W-1:0] sample;
   logic         sample_valid;

   logic [W-1:0] vin_r = '0;
   logic [2:0]   hist = '0;

   int n_tests = 0;
   int n_fail  = 0;

   sar_adc_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .cmp_in       (cmp_in),
      .dac_code     (dac_code),
      .busy         (busy),
      .sample       (sample),
      .sample_valid (sample_valid)
   );

   always #5 clk = ~clk;

   // Ideal comparator, 3 cycles of analog delay.
   always @(posedge clk) hist <= {hist[1:0], (dac_code <= vin_r)};
   assign cmp_in = hist[2];

   // Reference: binary search of an ideal comparator over the code space.
   function automatic logic [W-1:0] ref_sar(input logic [W-1:0] vin);
      int code = 0;
      for (int b = W - 1; b >= 0; b--) begin
         int trial = code + (1 << b);
         if (trial <= int'(vin)) code = trial;
      end
      return W'(code);
   endfunction

   task automatic convert_and_check(input logic [W-1:0] vin, input bit toggle, input string tag);
      logic [W-1:0] exp = ref_sar(vin);
      int n_valid = 0;
      int v_edge  = -1;
      vin_r = vin;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1;
      n_tests++;
      if (dac_code !== 10'h200) begin
         n_fail++;
         $display("FAIL %s msb_trial: dac_code got %h exp 200", tag, dac_code);
      end
      for (int e = 1; e <= LAT + 4; e++) begin
         @(negedge clk) start = toggle ? ((e % 2 == 0) && (e < LAT)) : 1'b0;
         @(posedge clk);
         #1;
         n_tests++;
         if (busy !== (e < LAT)) begin
            n_fail++;
            $display("FAIL %s busy edge %0d: got %b exp %b", tag, e, busy, (e < LAT));
         end
         if (sample_valid === 1'b1) begin
            n_valid++;
            v_edge = e;
            n_tests++;
            if (sample !== exp || dac_code !== exp) begin
               n_fail++;
               $display("FAIL %s result: sample %h dac %h exp %h", tag, sample, dac_code, exp);
            end
         end
      end
      n_tests++;
      if (n_valid != 1 || v_edge != LAT) begin
         n_fail++;
         $display("FAIL %s valid: count %0d at edge %0d exp 1 at edge %0d", tag, n_valid, v_edge, LAT);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (dac_code !== '0 || busy !== 1'b0 || sample !== '0 || sample_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: dac %h busy %b sample %h valid %b exp all 0",
                  dac_code, busy, sample, sample_valid);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      convert_and_check(10'h2A5, 1'b0, "single");
   endtask

   task automatic test_boundaries();
      convert_and_check(10'h3FF, 1'b0, "full_scale");
      convert_and_check(10'h000, 1'b0, "zero");
      convert_and_check(10'h200, 1'b0, "midscale");
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++) begin
         convert_and_check(W'($urandom_range(0, (1 << W) - 1)), 1'b0, "random");
      end
   endtask

   task automatic test_start_toggle();
      convert_and_check(10'h155, 1'b1, "start_toggle");
   endtask

   task automatic test_reset_mid();
      vin_r = 10'h1FF;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
      repeat (28) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      n_tests++;
      if (dac_code !== '0 || busy !== 1'b0 || sample !== '0 || sample_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: dac %h busy %b sample %h valid %b exp all 0",
                  dac_code, busy, sample, sample_valid);
      end
      @(negedge clk) rst_n = 1'b1;
      for (int e = 0; e < LAT + 5; e++) begin
         @(posedge clk);
         #1;
         n_tests++;
         if (sample_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_quiet cycle %0d: valid %b busy %b exp 0 0", e, sample_valid, busy);
         end
      end
      convert_and_check(10'h1FF, 1'b0, "restart");
   endtask

   task automatic test_back_to_back();
      int cyc = 0;
      int edges[$];
      vin_r = 10'h0F0;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      while (edges.size() < 3 && cyc < 5 * LAT) begin
         @(posedge clk);
         cyc++;
         #1;
         if (sample_valid === 1'b1) begin
            edges.push_back(cyc);
            n_tests++;
            if (sample !== ref_sar(10'h0F0)) begin
               n_fail++;
               $display("FAIL b2b sample: got %h exp %h", sample, ref_sar(10'h0F0));
            end
         end
      end
      start = 1'b0;
      n_tests++;
      if (edges.size() != 3) begin
         n_fail++;
         $display("FAIL b2b count: got %0d pulses exp 3", edges.size());
      end else begin
         n_tests++;
         if (edges[0] != LAT || edges[1] - edges[0] != PERIOD || edges[2] - edges[1] != PERIOD) begin
            n_fail++;
            $display("FAIL b2b spacing: edges %0d %0d %0d exp first %0d period %0d",
                     edges[0], edges[1], edges[2], LAT, PERIOD);
         end
      end
      cyc = 0;
      while (busy !== 1'b0 && cyc < 2 * LAT) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b drain: busy still %b after %0d cycles", busy, cyc);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_boundaries();
      test_random();
      test_start_toggle();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
